// File: rtl/uart_rx_frame.sv
// UART receive framer: 8N1 deframing on a 16x oversampling tick,
// one-deep output register with ready/ack handshake and error pulses.
module uart_rx_frame #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic                 baud_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST  = TW'(OVS - 1);
  localparam logic [BW-1:0] LASTB = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n, data_n;
  logic                 ready_n, ferr_n, ovr_n;
  logic                 rx_m, rx_s;

  assign baud_en = ~rst;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      rx_data   <= data_n;
      rx_ready  <= ready_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    data_n     = rx_data;
    ready_n    = rx_ready & ~rx_ack;
    ferr_n     = 1'b0;
    ovr_n      = 1'b0;
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n    = START;
            tick_cnt_n = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            // still low at mid start bit: real frame, else a glitch
            state_n    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == LAST) begin
            tick_cnt_n = '0;
            shift_n    = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt_n  = bit_cnt + BW'(1);
            if (bit_cnt == LASTB) state_n = STOP;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == LAST) begin
            tick_cnt_n = '0;
            if (rx_s) begin
              // a new byte beats a same-cycle ack
              data_n  = shift_reg;
              ready_n = 1'b1;
              ovr_n   = rx_ready & ~rx_ack;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        BRK: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
